// File: rtl/bus_pkg.sv
// Frame layout, Pi handshake states and output bundle shared by the bus slot scheduler.
// One frame is 16 clk16 cycles: Pi slot, video fetch slot, then the CPU slot.
package bus_pkg;

    localparam int unsigned FRAME_LEN = 16;
    localparam logic [3:0]  FRAME_LAST = 4'(FRAME_LEN - 1);

    localparam logic [3:0] PI_SLOT_FIRST   = 4'd0;
    localparam logic [3:0] PI_SLOT_LAST    = 4'd3;
    localparam logic [3:0] PI_STROBE_FIRST = 4'd1;
    localparam logic [3:0] PI_STROBE_LAST  = 4'd2;
    localparam logic [3:0] VID_SLOT_FIRST  = 4'd4;
    localparam logic [3:0] VID_SLOT_LAST   = 4'd7;
    localparam logic [3:0] VID_RAM_STROBE  = 4'd5;
    localparam logic [3:0] VID_ROM_STROBE  = 4'd7;
    localparam logic [3:0] CPU_SLOT_FIRST  = 4'd8;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StDone
    } pi_state_e;

    typedef struct packed {
        logic phi2;
        logic cpu_be;
        logic video_select;
        logic video_ram_strobe;
        logic video_rom_strobe;
        logic pi_select;
        logic pi_read;
        logic pi_write;
    } slot_out_t;

    function automatic logic in_slot(logic [3:0] pos, logic [3:0] first, logic [3:0] last);
        return (pos >= first) && (pos <= last);
    endfunction

endpackage

// File: rtl/pi_handshake.sv
// RPi four-phase handshake: synchronises pi_pending and grants one Pi slot per request.
// A new grant is only possible once the request has been seen low again after done.
module pi_handshake
    import bus_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pi_pending_i,
    input  logic pi_rw_b_i,
    input  logic frame_end_i,
    input  logic pi_slot_end_i,
    output logic pi_granted_o,
    output logic pi_rw_q_o,
    output logic pi_done_o
);

    logic [1:0] sync_q;
    logic       pend_s;
    pi_state_e  state_q, state_d;
    logic       pi_rw_q, pi_rw_d;
    logic       done_q;

    assign pend_s = sync_q[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= 2'b00;
            state_q <= StIdle;
            pi_rw_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], pi_pending_i};
            state_q <= state_d;
            pi_rw_q <= pi_rw_d;
            done_q  <= (state_d == StDone);
        end
    end

    always_comb begin
        state_d = state_q;
        pi_rw_d = pi_rw_q;
        unique case (state_q)
            StIdle: begin
                if (frame_end_i && pend_s) begin
                    state_d = StGrant;
                    pi_rw_d = pi_rw_b_i;
                end
            end
            StGrant: begin
                if (pi_slot_end_i) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!pend_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Next-state grant, so the top can register its Pi outputs for the coming count.
    assign pi_granted_o = (state_d == StGrant);
    assign pi_rw_q_o    = pi_rw_q;
    assign pi_done_o    = done_q;

endmodule

// File: rtl/bus_slot_scheduler.sv
// Fixed-frame time-division scheduler for the shared RAM/address/data bus (16 MHz, 1 us frame).
// Outputs are registered from the next count so they align with slot_count and are glitch-free.
module bus_slot_scheduler
    import bus_pkg::*;
#(
    parameter int unsigned PHI2_START = 12
) (
    input  logic       clk16,
    input  logic       reset_b,
    input  logic       bus_rw_b,
    input  logic       video_enable,
    input  logic       pi_pending,
    input  logic       pi_rw_b,
    output logic [3:0] slot_count,
    output logic       clk8,
    output logic       phi2,
    output logic       cpu_be,
    output logic       cpu_read,
    output logic       cpu_write,
    output logic       video_select,
    output logic       video_ram_strobe,
    output logic       video_rom_strobe,
    output logic       pi_select,
    output logic       pi_read,
    output logic       pi_write,
    output logic       pi_done
);

    localparam logic [3:0] Phi2First = 4'(PHI2_START);

    logic [3:0] count_q, count_d;
    logic       vid_en_q, vid_en_d;
    slot_out_t  out_q, out_d;
    logic       pi_granted;
    logic       pi_rw_q;

    pi_handshake u_pi_handshake (
        .clk_i         (clk16),
        .rst_ni        (reset_b),
        .pi_pending_i  (pi_pending),
        .pi_rw_b_i     (pi_rw_b),
        .frame_end_i   (count_q == FRAME_LAST),
        .pi_slot_end_i (count_q == PI_SLOT_LAST),
        .pi_granted_o  (pi_granted),
        .pi_rw_q_o     (pi_rw_q),
        .pi_done_o     (pi_done)
    );

    always_ff @(posedge clk16 or negedge reset_b) begin
        if (!reset_b) begin
            count_q  <= 4'd0;
            vid_en_q <= 1'b0;
            out_q    <= '0;
        end else begin
            count_q  <= count_d;
            vid_en_q <= vid_en_d;
            out_q    <= out_d;
        end
    end

    always_comb begin
        count_d = count_q + 4'd1;
        // video_enable is sampled on the edge that enters the video slot and held for it.
        vid_en_d = (count_d == VID_SLOT_FIRST) ? video_enable : vid_en_q;

        out_d                  = '0;
        out_d.phi2             = (count_d >= Phi2First);
        out_d.cpu_be           = (count_d >= CPU_SLOT_FIRST);
        out_d.video_select     = in_slot(count_d, VID_SLOT_FIRST, VID_SLOT_LAST) && vid_en_d;
        out_d.video_ram_strobe = (count_d == VID_RAM_STROBE) && vid_en_d;
        out_d.video_rom_strobe = (count_d == VID_ROM_STROBE) && vid_en_d;
        out_d.pi_select        = in_slot(count_d, PI_SLOT_FIRST, PI_SLOT_LAST) && pi_granted;
        out_d.pi_read  = in_slot(count_d, PI_STROBE_FIRST, PI_STROBE_LAST) && pi_granted && pi_rw_q;
        out_d.pi_write = in_slot(count_d, PI_STROBE_FIRST, PI_STROBE_LAST) && pi_granted && !pi_rw_q;
    end

    assign slot_count       = count_q;
    assign clk8             = count_q[0];
    assign phi2             = out_q.phi2;
    assign cpu_be           = out_q.cpu_be;
    assign cpu_read         = bus_rw_b && out_q.phi2;
    assign cpu_write        = !bus_rw_b && out_q.phi2;
    assign video_select     = out_q.video_select;
    assign video_ram_strobe = out_q.video_ram_strobe;
    assign video_rom_strobe = out_q.video_rom_strobe;
    assign pi_select        = out_q.pi_select;
    assign pi_read          = out_q.pi_read;
    assign pi_write         = out_q.pi_write;

endmodule
